// File: rtl/bfp_pkg.sv
// Shared constants, types and helpers for the BFP-to-FP conversion pipeline.
// Optional round-to-nearest-even is selected with the BFP2FP_RNE_EN macro in the top.
package bfp_pkg;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int fp_emax(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  function automatic int pos_w(input int mw);
    return (mw > 1) ? $clog2(mw) : 1;
  endfunction

  localparam int BIT_DEF   = 32;
  localparam int FPM_DEF   = 23;
  localparam int EXP_DEF   = BIT_DEF - FPM_DEF - 1;
  localparam int MW_DEF    = 12;
  localparam int POS_W_DEF = pos_w(MW_DEF);

  typedef struct packed {
    logic               sign;
    logic [EXP_DEF-1:0] exp;
    logic [FPM_DEF-1:0] frac;
  } fp_word_t;

  typedef enum logic [1:0] {
    LANE_NORMAL,
    LANE_ZERO,
    LANE_INF,
    LANE_FLUSH
  } lane_class_e;

endpackage

// File: rtl/bfp_lzd.sv
// Combinational leading-one detector: bit position of the most significant set bit
// plus an all-zero flag (position reads 0 when the input is zero).
module bfp_lzd
  import bfp_pkg::*;
#(
  parameter int unsigned MW = 12,
  parameter int unsigned PW = pos_w(MW)
) (
  input  logic [MW-1:0] mant_i,
  output logic [PW-1:0] pos_o,
  output logic          zero_o
);

  // Ascending scan: the last set bit seen is the leading one.
  always_comb begin
    pos_o = '0;
    for (int unsigned i = 0; i < MW; i++) begin
      if (mant_i[i]) pos_o = PW'(i);
    end
  end

  assign zero_o = ~|mant_i;

endmodule

// File: rtl/bfp_to_fp_pipe.sv
// Two-stage elastic converter from block floating point to per-lane FP words.
// Define BFP2FP_RNE_EN for round-to-nearest-even; otherwise discarded bits truncate.
module bfp_to_fp_pipe
  import bfp_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned BIT   = 32,
  parameter int unsigned FPM   = 23,
  parameter int unsigned MW    = 12,
  parameter int unsigned FRAC  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*MW-1:0]    in_mant,
  input  logic [LANES-1:0]       in_sign,
  input  logic [BIT-FPM-2:0]     in_exp,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*BIT-1:0]   out_fp
);

  localparam int unsigned EXP = BIT - FPM - 1;
  localparam int unsigned PW  = pos_w(MW);
  localparam int unsigned EW  = EXP + 2;

  localparam logic signed [EW-1:0] E_OFFSET = EW'(fp_bias(EXP) - int'(FRAC));
  localparam logic signed [EW-1:0] E_MAX    = EW'(fp_emax(EXP));
  localparam logic signed [EW-1:0] E_ZERO   = '0;
  localparam logic signed [EW-1:0] E_ONE    = EW'(1);

  // Stage 1 registers
  logic                 s1_valid_q;
  logic [LANES*MW-1:0]  s1_mant_q;
  logic [LANES-1:0]     s1_sign_q;
  logic [LANES-1:0]     s1_zero_q;
  logic [EXP-1:0]       s1_exp_q;
  logic [LANES*PW-1:0]  s1_pos_q;

  // Stage 2 (output) registers
  logic                 out_valid_q;
  logic [LANES*BIT-1:0] out_fp_q;

  logic [LANES*PW-1:0]  lzd_pos;
  logic [LANES-1:0]     lzd_zero;
  logic [LANES*BIT-1:0] s2_fp_d;

  logic out_free;
  logic s1_advance;
  logic in_accept;

  // Output slot is free when empty or draining this cycle, so a full pipe
  // still accepts a new beat whenever the downstream takes one.
  assign out_free   = !out_valid_q || out_ready;
  assign s1_advance = s1_valid_q && out_free;
  assign in_ready   = !reset && (!s1_valid_q || s1_advance);
  assign in_accept  = in_valid && in_ready;

  for (genvar g = 0; g < LANES; g++) begin : g_lzd
    bfp_lzd #(
      .MW (MW),
      .PW (PW)
    ) u_lzd (
      .mant_i (in_mant[g*MW +: MW]),
      .pos_o  (lzd_pos[g*PW +: PW]),
      .zero_o (lzd_zero[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_accept) begin
      s1_mant_q <= in_mant;
      s1_sign_q <= in_sign;
      s1_zero_q <= lzd_zero;
      s1_exp_q  <= in_exp;
      s1_pos_q  <= lzd_pos;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [MW-1:0]          mant;
    logic [PW-1:0]          pos;
    logic [PW-1:0]          shamt;
    logic [MW-2:0]          below;
    logic [FPM-1:0]         frac_t;
    logic                   round_up;
    logic [FPM:0]           frac_r;
    logic signed [EW-1:0]   e_base;
    logic signed [EW-1:0]   e_fin;
    lane_class_e            cls;
    logic [EXP-1:0]         exp_f;
    logic [FPM-1:0]         frac_f;
    logic [BIT-1:0]         fp_lane;

    assign mant  = s1_mant_q[g*MW +: MW];
    assign pos   = s1_pos_q[g*PW +: PW];
    assign shamt = PW'(MW - 1) - pos;
    // Shifting the leading one to bit MW-1 and dropping it leaves the fraction bits.
    assign below = (MW-1)'(mant << shamt);

    if (MW - 1 == FPM) begin : g_exact
      assign frac_t   = below;
      assign round_up = 1'b0;
    end else if (MW - 1 < FPM) begin : g_fill
      assign frac_t   = {below, {(FPM - (MW - 1)){1'b0}}};
      assign round_up = 1'b0;
    end else begin : g_wide
      assign frac_t = below[MW-2 -: FPM];
`ifdef BFP2FP_RNE_EN
      logic guard;
      logic sticky;
      assign guard = below[MW-2-FPM];
      if (MW - 2 - FPM > 0) begin : g_sticky
        assign sticky = |below[MW-3-FPM:0];
      end else begin : g_no_sticky
        assign sticky = 1'b0;
      end
      assign round_up = guard && (sticky || frac_t[0]);
`else
      logic unused_discard;
      assign unused_discard = ^below[MW-2-FPM:0];
      assign round_up       = 1'b0;
`endif
    end

    assign frac_r = {1'b0, frac_t} + (FPM+1)'(round_up);
    assign e_base = $signed({{2{s1_exp_q[EXP-1]}}, s1_exp_q})
                  + $signed({{(EW-PW){1'b0}}, pos})
                  + E_OFFSET;
    // A rounding carry leaves frac_r[FPM-1:0] at zero, i.e. the next binade.
    assign e_fin  = frac_r[FPM] ? e_base + E_ONE : e_base;

    always_comb begin
      cls = LANE_NORMAL;
      if (s1_zero_q[g]) begin
        cls = LANE_ZERO;
      end else if (e_fin >= E_MAX) begin
        cls = LANE_INF;
      end else if (e_fin <= E_ZERO) begin
        cls = LANE_FLUSH;
      end
    end

    always_comb begin
      exp_f  = '0;
      frac_f = '0;
      case (cls)
        LANE_NORMAL: begin
          exp_f  = e_fin[EXP-1:0];
          frac_f = frac_r[FPM-1:0];
        end
        LANE_INF: exp_f = '1;
        default: ;
      endcase
      fp_lane = {s1_sign_q[g], exp_f, frac_f};
    end

    assign s2_fp_d[g*BIT +: BIT] = fp_lane;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_fp_q    <= '0;
    end else if (out_free) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) out_fp_q <= s2_fp_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_fp    = out_fp_q;

endmodule
